// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control for the 5-stage pipeline.
// Resolves three conditions: load-use stalls, taken-branch flushes and MUL/DIV
// occupancy of EX. It also keeps a saturating count of stalled cycles.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_LAT      = 4,
    parameter int unsigned DIV_LAT      = 32,
    parameter bit          BRANCH_FLUSH = 1'b1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch_taken,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_muldiv,
    input  logic             ex_is_div,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            md_stall;
    logic            lu_hazard;
    logic [CNT_W-1:0] stall_cnt;

    // MUL/DIV occupancy FSM; ex_muldiv is only looked at in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_muldiv) begin
                        state <= BUSY;
                        cnt   <= ex_is_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Hazard detection; r0 is never a real dependency
    always_comb begin
        md_stall  = ((state == RUN) && ex_muldiv) || ((state == BUSY) && (cnt != '0));
        lu_hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    end

    // Stage enables and flushes, priority md_stall > load-use > branch
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (rst) begin
            if (md_stall) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
            end else if (lu_hazard) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (id_branch_taken && BRANCH_FLUSH) begin
                if_id_flush = 1'b1;
            end
        end
    end

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign md_busy      = rst && (state == BUSY);
    assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares every cycle.
module tb_pipe_hazard_ctrl;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush}
    localparam logic [5:0] N = 6'b110100;
    localparam logic [5:0] L = 6'b000110;
    localparam logic [5:0] M = 6'b000001;
    localparam logic [5:0] B = 6'b111100;

    typedef struct {
        logic [5:0]  ctrl;
        logic        busy;
        logic        cnt_ok;
        logic [31:0] cnt0;
        logic [2:0]  cnt1;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic id_use_rs, id_use_rt, id_branch_taken, ex_mem_read, ex_muldiv, ex_is_div;

    logic pc_en0, if_id_en0, if_id_flush0, id_ex_en0, id_ex_flush0, ex_mem_flush0, md_busy0;
    logic [31:0] stall0;
    logic pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1, ex_mem_flush1, md_busy1;
    logic [2:0] stall1;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    logic        model_ok = 1'b0;
    logic [31:0] model0 = '0;
    logic [2:0]  model1 = '0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .BRANCH_FLUSH(1'b1), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_branch_taken(id_branch_taken), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_muldiv(ex_muldiv), .ex_is_div(ex_is_div),
        .pc_en(pc_en0), .if_id_en(if_id_en0), .if_id_flush(if_id_flush0), .id_ex_en(id_ex_en0),
        .id_ex_flush(id_ex_flush0), .ex_mem_flush(ex_mem_flush0), .md_busy(md_busy0),
        .stall_cycles(stall0)
    );

    pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .BRANCH_FLUSH(1'b0), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_branch_taken(id_branch_taken), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_muldiv(ex_muldiv), .ex_is_div(ex_is_div),
        .pc_en(pc_en1), .if_id_en(if_id_en1), .if_id_flush(if_id_flush1), .id_ex_en(id_ex_en1),
        .id_ex_flush(id_ex_flush1), .ex_mem_flush(ex_mem_flush1), .md_busy(md_busy1),
        .stall_cycles(stall1)
    );

    // Drive one cycle of inputs and push the expected response for that cycle
    task automatic step(input int r, input int rs, input int rt, input int urs, input int urt,
                        input int br, input int mr, input int rd, input int md, input int dv,
                        input logic [5:0] ex, input int bz);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = 1'(r);
        id_rs           = 5'(rs);
        id_rt           = 5'(rt);
        id_use_rs       = 1'(urs);
        id_use_rt       = 1'(urt);
        id_branch_taken = 1'(br);
        ex_mem_read     = 1'(mr);
        ex_rd           = 5'(rd);
        ex_muldiv       = 1'(md);
        ex_is_div       = 1'(dv);
        e.ctrl   = ex;
        e.busy   = 1'(bz);
        e.cnt_ok = model_ok;
        e.cnt0   = model0;
        e.cnt1   = model1;
        q.push_back(e);
        if (r == 0) begin
            model_ok = 1'b1;
            model0   = '0;
            model1   = '0;
        end else if (!ex[5]) begin
            if (model0 != '1) model0 = model0 + 32'd1;
            if (model1 != '1) model1 = model1 + 3'd1;
        end
    endtask

    // Monitor: compare both instances against the popped expectation
    always @(negedge clk) begin
        exp_t e;
        logic [5:0] a0, a1, x1;
        if (q.size() > 0) begin
            e  = q.pop_front();
            a0 = {pc_en0, if_id_en0, if_id_flush0, id_ex_en0, id_ex_flush0, ex_mem_flush0};
            a1 = {pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1, ex_mem_flush1};
            x1 = (e.ctrl == B) ? N : e.ctrl;
            checks++;
            if (a0 !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl0 t=%0t got=%b exp=%b", $time, a0, e.ctrl);
            end
            checks++;
            if (a1 !== x1) begin
                errors++;
                $display("FAIL ctrl1 t=%0t got=%b exp=%b", $time, a1, x1);
            end
            checks++;
            if (md_busy0 !== e.busy || md_busy1 !== e.busy) begin
                errors++;
                $display("FAIL md_busy t=%0t got=%b/%b exp=%b", $time, md_busy0, md_busy1, e.busy);
            end
            if (e.cnt_ok) begin
                checks++;
                if (stall0 !== e.cnt0) begin
                    errors++;
                    $display("FAIL stall0 t=%0t got=%0d exp=%0d", $time, stall0, e.cnt0);
                end
                checks++;
                if (stall1 !== e.cnt1) begin
                    errors++;
                    $display("FAIL stall1_sat t=%0t got=%0d exp=%0d", $time, stall1, e.cnt1);
                end
            end
        end else if (done) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_branch_taken = 1'b0;
        ex_mem_read = 1'b0; ex_muldiv = 1'b0; ex_is_div = 1'b0;

        // reset held with ex_muldiv asserted
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, N, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);

        // load-use on rs, then clean cycle
        step(1, 8, 0, 1, 0, 0, 1, 8, 0, 0, L, 0);
        step(1, 8, 0, 1, 0, 0, 0, 8, 0, 0, N, 0);
        // r0 never hazards
        step(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, N, 0);
        // load-use on rt; rs match without use_rs does not hazard
        step(1, 3, 9, 0, 1, 0, 1, 9, 0, 0, L, 0);
        step(1, 9, 4, 0, 1, 0, 1, 9, 0, 0, N, 0);

        // taken branch alone, then with load-use
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, B, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
        step(1, 5, 0, 1, 0, 1, 1, 5, 0, 0, L, 0);
        step(1, 5, 0, 1, 0, 1, 0, 5, 0, 0, B, 0);

        // MUL latency 4: detect + 3 BUSY stalls, then release cycle with md held
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, M, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, M, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, N, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);

        // DIV latency 32 with load-use and branch present throughout
        step(1, 8, 0, 1, 0, 1, 1, 8, 1, 1, M, 0);
        for (int i = 0; i < 31; i++) step(1, 8, 0, 1, 0, 1, 1, 8, 1, 1, M, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);

        // reset in the 10th BUSY cycle of a DIV
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, M, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, M, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
        step(1, 8, 0, 1, 0, 0, 1, 8, 0, 0, L, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0);

        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage dynamic pipeline. It sequences the PC, IF/ID, ID/EX and EX/MEM registers by generating per-cycle enable (hold) and flush (bubble) controls. It resolves three conditions:
- load-use data hazards, by stalling the front end one cycle;
- taken branches resolved in ID, by flushing the wrong-path fetch;
- multi-cycle MUL/DIV occupancy of EX, via a small busy FSM with a latency counter.

It also keeps a saturating stall-cycle counter for performance analysis.

## Interface
Parameters:
- MUL_LAT, 4, EX cycles a MULT/MULTU occupies beyond the first; legal range 1..63
- DIV_LAT, 32, same for DIV/DIVU; legal range 1..63
- BRANCH_FLUSH, 1, 1 = flush IF/ID on a taken branch; 0 = delay-slot mode, no flush
- CNT_W, 32, width of the stall counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_branch_taken  in  1  branch/jump in ID resolved taken this cycle
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_muldiv  in  1  level: EX holds a MULT/DIV instruction
- ex_is_div  in  1  qualifies ex_muldiv: 1 = DIV latency, 0 = MUL latency
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP (overrides if_id_en)
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX loads a bubble
- ex_mem_flush  out  1  EX/MEM loads a bubble
- md_busy  out  1  FSM is in BUSY
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en==0

## Operation
- FSM states: RUN, BUSY. A 6-bit down-counter `cnt` belongs to the FSM.
- RUN → BUSY when `ex_muldiv`=1 at the edge; `cnt` ← (ex_is_div ? DIV_LAT : MUL_LAT) − 1.
- In BUSY with `cnt`≠0: `cnt` decrements each cycle. In BUSY with `cnt`==0: next state is RUN.
- `ex_muldiv` is sampled only in RUN. It is ignored in BUSY, so the instruction leaving EX in the release cycle never restarts the FSM.
- md_stall = (RUN && ex_muldiv) || (BUSY && cnt≠0).
- lu_hazard = ex_mem_read && ex_rd≠0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
- Priority, highest first: md_stall > lu_hazard > id_branch_taken.
- When md_stall: pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1; all other flushes are 0. The whole front end is frozen with no bubble into EX.
- Else when lu_hazard: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, if_id_flush=0. A taken branch is suppressed because its operands are not ready.
- Else when id_branch_taken && BRANCH_FLUSH: all enables are 1 and if_id_flush=1.
- Otherwise: all enables are 1 and all flushes are 0.
- stall_cycles increments in every cycle with pc_en==0 and holds at 2^CNT_W−1.
- Register r0 never causes a hazard.

## Timing
- Enables and flushes are combinational from the current state and inputs, and are valid in the same cycle.
- `md_busy`, `cnt` and `stall_cycles` are registered.
- MUL/DIV with latency L stalls exactly L cycles: the detect cycle plus L−1 BUSY cycles. The instruction then stays in EX for one more, unstalled cycle and leaves EX at the end of it. Total EX occupancy is L+1 cycles.
- A load-use stall lasts exactly 1 cycle. The next cycle sees the load in MEM and no hazard.
- While rst==0:
  - next state is RUN, `cnt`=0, stall_cycles=0;
  - outputs are forced to pc_en=if_id_en=id_ex_en=1, all flushes 0, md_busy=0.
- rst asserted mid-BUSY aborts the operation. The first cycle after release is RUN with no stall.
- Simultaneous load-use and taken branch: stall only, no flush. The branch is re-evaluated the next cycle.
- ex_muldiv and lu_hazard in the same cycle: md_stall wins. Because ID/EX is frozen, the load-use check repeats after release.

## Test plan
- Reset: hold rst=0 for 3 cycles with ex_muldiv=1 → md_busy=0, stall_cycles=0, pc_en=1, all flushes 0.
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle (ex_mem_read=0) all enables 1; stall_cycles=1. Repeat with ex_rd=0 → no stall.
- MUL, MUL_LAT=4: ex_muldiv=1, ex_is_div=0 held → pc_en=0 for exactly 4 cycles, md_busy=1 for 3 of them, ex_mem_flush=1 for the 4 stalled cycles; 5th cycle pc_en=1, md_busy=1, cnt=0; 6th cycle RUN.
- DIV, DIV_LAT=32, with a load-use and a taken branch present throughout → exactly 32 stalled cycles, no if_id_flush or id_ex_flush during them, stall_cycles=32.
- Branch: id_branch_taken=1, no hazard → if_id_flush=1 for 1 cycle, pc_en=1. With BRANCH_FLUSH=0 → if_id_flush=0. With a simultaneous load-use → if_id_flush=0, id_ex_flush=1.
- Reset mid-DIV: rst=0 in the 10th BUSY cycle → the next cycle is RUN, md_busy=0, enables 1.
